// File: rtl/button_mmio.sv
// button_mmio: synchronized, debounced push-buttons with sticky press flags,
// press counter and LED register on the core's unified memory bus.
module button_mmio #(
  parameter int          N_BTN           = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          N_LED           = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  input  logic             MemWrite,
  input  logic [N_BTN-1:0] btn_in,
  output logic [31:0]      ReadData,
  output logic             sel_q,
  output logic [N_LED-1:0] leds
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_BTN-1:0] s1, s2, stable, ev, term, rise, clr;
  logic [CW-1:0]    cnt [N_BTN];
  logic [31:0]      press_cnt, pc, rdata;
  logic             hit, wr;
  logic [1:0]       off;
  assign hit = Address[31:4] == BASE_ADDR[31:4];
  assign off = Address[3:2];
  assign wr  = MemWrite && hit;
  // term: the new level has persisted long enough and is accepted this edge
  always_comb begin
    term = '0;
    rise = '0;
    pc   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      term[i] = (s2[i] != stable[i]) && (cnt[i] == CMAX);
      rise[i] = term[i] && s2[i];
      pc      = pc + 32'(rise[i]);
    end
    clr   = (wr && off == 2'd1) ? WriteData[N_BTN-1:0] : '0;
    rdata = off == 2'd0 ? 32'(stable) :
            off == 2'd1 ? 32'(ev) :
            off == 2'd2 ? 32'(leds) : press_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      stable    <= '0;
      ev        <= '0;
      press_cnt <= '0;
      leds      <= '0;
      ReadData  <= '0;
      sel_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      for (int i = 0; i < N_BTN; i++)
        cnt[i] <= (s2[i] == stable[i] || term[i]) ? '0 : cnt[i] + CW'(1);
      stable    <= stable ^ term;
      ev        <= (ev & ~clr) | rise;
      press_cnt <= (wr && off == 2'd3) ? WriteData : press_cnt + pc;
      leds      <= (wr && off == 2'd2) ? WriteData[N_LED-1:0] : leds;
      ReadData  <= hit ? rdata : '0;
      sel_q     <= hit;
    end
  end
endmodule

// File: tb/tb_button_mmio.sv
// tb_button_mmio: directed vectors for button_mmio with 4 buttons, 4-cycle debounce.
module tb_button_mmio;
  logic        clk, reset, MemWrite, sel_q;
  logic [31:0] Address, WriteData, ReadData, d;
  logic [3:0]  btn_in;
  logic [7:0]  leds;
  int          n_chk, n_fail;
  button_mmio #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .N_LED(8), .BASE_ADDR(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
    .btn_in(btn_in), .ReadData(ReadData), .sel_q(sel_q), .leds(leds)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    Address = a;
    MemWrite = 1'b0;
    tick();
    v = ReadData;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    Address = a;
    WriteData = v;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    MemWrite = 1'b0;
    Address = 32'h0;
    WriteData = 32'h0;
    btn_in = 4'h0;
    tick(2);
    reset = 1'b0;
    // reset / idle
    for (int a = 0; a < 4; a++) begin
      rd(32'h1000 + 32'(a * 4), d);
      check($sformatf("idle_rd%0d", a), d, 32'h0);
      check($sformatf("idle_sel%0d", a), {31'h0, sel_q}, 32'h1);
    end
    rd(32'h2000, d);
    check("miss_rd", d, 32'h0);
    check("miss_sel", {31'h0, sel_q}, 32'h0);
    check("idle_leds", {24'h0, leds}, 32'h0);
    // clean press: stable rises at edge k+5, visible in ReadData after edge k+6
    Address = 32'h1000;
    btn_in = 4'h2;
    tick(6);
    check("press_early", ReadData, 32'h0);
    tick();
    check("press_state", ReadData, 32'h2);
    rd(32'h1004, d); check("press_ev", d, 32'h2);
    rd(32'h100C, d); check("press_cnt", d, 32'h1);
    btn_in = 4'h0;
    tick(10);
    rd(32'h1000, d); check("rel_state", d, 32'h0);
    rd(32'h1004, d); check("rel_ev", d, 32'h2);
    rd(32'h100C, d); check("rel_cnt", d, 32'h1);
    // glitch of 3 cycles must not qualify
    wr(32'h1004, 32'hF);
    wr(32'h100C, 32'h0);
    btn_in = 4'h1;
    tick(3);
    btn_in = 4'h0;
    tick(10);
    rd(32'h1000, d); check("glitch_state", d, 32'h0);
    rd(32'h1004, d); check("glitch_ev", d, 32'h0);
    rd(32'h100C, d); check("glitch_cnt", d, 32'h0);
    // simultaneous presses and W1C
    btn_in = 4'h9;
    tick(12);
    rd(32'h1000, d); check("sim_state", d, 32'h9);
    rd(32'h1004, d); check("sim_ev", d, 32'h9);
    rd(32'h100C, d); check("sim_cnt", d, 32'h2);
    wr(32'h1004, 32'h1);
    rd(32'h1004, d); check("w1c_ev", d, 32'h8);
    btn_in = 4'h1;
    tick(12);
    wr(32'h1004, 32'h8);
    rd(32'h1004, d); check("w1c_clr3", d, 32'h0);
    btn_in = 4'h9;
    tick(5);
    wr(32'h1004, 32'h8);
    rd(32'h1004, d); check("set_wins", d, 32'h8);
    rd(32'h100C, d); check("set_cnt", d, 32'h3);
    // LED and counter writes
    wr(32'h1008, 32'hA5);
    check("leds", {24'h0, leds}, 32'hA5);
    rd(32'h1008, d); check("led_rd", d, 32'hA5);
    wr(32'h100C, 32'hFFFF_FFFF);
    rd(32'h100C, d); check("cnt_load", d, 32'hFFFF_FFFF);
    btn_in = 4'hB;
    tick(10);
    rd(32'h100C, d); check("cnt_wrap", d, 32'h0);
    btn_in = 4'h9;
    tick(10);
    btn_in = 4'hB;
    tick(5);
    wr(32'h100C, 32'd100);
    rd(32'h100C, d); check("cnt_wr_wins", d, 32'd100);
    // reset mid-debounce with btn 2 held
    btn_in = 4'h0;
    tick(10);
    Address = 32'h1000;
    btn_in = 4'h4;
    tick(4);
    reset = 1'b1;
    tick(2);
    check("rst_leds", {24'h0, leds}, 32'h0);
    check("rst_rd", ReadData, 32'h0);
    check("rst_sel", {31'h0, sel_q}, 32'h0);
    reset = 1'b0;
    tick(6);
    check("rst_early", ReadData, 32'h0);
    tick();
    check("rst_state", ReadData, 32'h4);
    rd(32'h1004, d); check("rst_ev", d, 32'h4);
    rd(32'h100C, d); check("rst_cnt", d, 32'h1);
    rd(32'h1008, d); check("rst_led_rd", d, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
